pin_input_conditioner: RTL and testbench
========================================

Name: pin_input_conditioner

Overview:
- Core-side consumer of the raw per-pin input values produced by the pad ring (`from_pins_o` of the pad instances).
- Per pin, it synchronises the asynchronous pad input and optionally debounces it.
- It detects rising and falling edges and holds sticky, maskable interrupt status.
- Feeds GPIO and peripheral input muxing; it is the only place pad inputs enter the clock domain.

Parameters:
- `NumberOfPins`, 1, number of pins handled; each pin is processed independently.
- `SyncStages`, 2, synchroniser flop depth; legal range ≥ 2.
- `DebounceCycles`, 16, consecutive stable cycles needed to accept a new value; legal range ≥ 1.

Ports:
- `clk_i` input 1: system clock.
- `rst_ni` input 1: asynchronous active-low reset.
- `from_pins_i` input 1 [NumberOfPins]: raw pad input values, asynchronous to `clk_i`.
- `debounce_en_i` input NumberOfPins: per-pin debounce enable.
- `rise_en_i` input NumberOfPins: per-pin rising-edge interrupt enable.
- `fall_en_i` input NumberOfPins: per-pin falling-edge interrupt enable.
- `intr_clear_i` input NumberOfPins: per-pin write-1-to-clear pulse for `intr_state_o`.
- `pin_value_o` output NumberOfPins: conditioned pin value.
- `rise_o` output NumberOfPins: one-cycle pulse on an accepted 0→1 transition.
- `fall_o` output NumberOfPins: one-cycle pulse on an accepted 1→0 transition.
- `intr_state_o` output NumberOfPins: sticky edge status.
- `intr_o` output 1: OR-reduction of `intr_state_o`.

Behaviour:
- Reset:
  - Clock `clk_i`; reset `rst_ni` is asynchronous, active-low.
  - All flops reset to 0: synchroniser, `value_q`, `prev_q`, counters and `intr_state`.
  - Outputs during and immediately after reset: `pin_value_o`=0, `rise_o`=0, `fall_o`=0, `intr_state_o`=0, `intr_o`=0.
  - A pin held high through reset yields one `rise_o` pulse once its value is accepted.
- Synchroniser:
  - `SyncStages` flops per pin; `sync` is the last stage.
  - An input change is visible on `sync` `SyncStages` rising edges later.
- Debounce, per pin (debounce enabled):
  - Counter width `$clog2(DebounceCycles+1)`.
  - `sync` == `value_q`: counter ← 0 (glitch rejected).
  - `sync` != `value_q` and counter == `DebounceCycles`-1: `value_q` ← `sync`, counter ← 0.
  - `sync` != `value_q`, otherwise: counter ← counter+1.
  - Result: `value_q` updates on the `DebounceCycles`-th consecutive mismatching edge.
  - Total latency from pad change to `pin_value_o` = `SyncStages`+`DebounceCycles` edges.
- Debounce disabled (`debounce_en_i`[i]=0):
  - `value_q` ← `sync` every edge; counter held at 0.
  - Latency `SyncStages`+1.
  - Deasserting mid-count discards the count; the next edge loads `sync`.
  - Asserting mid-operation starts counting from 0.
- Output value: `pin_value_o` = `value_q`.
- Edge detect:
  - `prev_q` ← `value_q` every edge.
  - `rise_o` = `value_q` & ~`prev_q`; `fall_o` = ~`value_q` & `prev_q`.
  - Each pulse is exactly one cycle, coincident with the first cycle `pin_value_o` shows the new value.
- Interrupt state, per pin:
  - set = (`rise_o` & `rise_en_i`) | (`fall_o` & `fall_en_i`).
  - `intr_state` ← set | (`intr_state` & ~`intr_clear_i`).
  - Set wins over a simultaneous clear.
  - Clearing an already-clear bit has no effect.
  - Enables gate only new sets; disabling an enable does not clear existing state.
- Interrupt output: `intr_o` is combinational from `intr_state_o`.

Optional Feature:
- Macro: `PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN`.
- Defined:
  - Adds input `glitch_clear_i` (NumberOfPins) and output `glitch_count_o` (8×NumberOfPins, packed, pin i at [8i+7:8i]).
  - Per pin, an 8-bit counter increments on each rejected glitch: debounce enabled, counter nonzero, and `sync` == `value_q`.
  - The counter saturates at 255 and resets to 0.
  - `glitch_clear_i`[i] zeroes it; clear wins over a simultaneous increment.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with `from_pins_i`=1, `debounce_en_i`=0, `rise_en_i`=1 → after release:
  - `pin_value_o`=1 at edge 3.
  - `rise_o` high for 1 cycle.
  - `intr_state_o`=1, `intr_o`=1.
- Debounce on, `DebounceCycles`=16, `SyncStages`=2, pin 0→1 held:
  - `pin_value_o` rises exactly 18 edges after the change.
  - One `rise_o` pulse.
  - `fall_o` stays 0.
- Debounce on, 10-cycle high glitch:
  - `pin_value_o` stays 0; no `rise_o`.
  - With the macro: `glitch_count_o`=1.
  - 300 such glitches → `glitch_count_o`=255.
- `intr_state` set pending, `intr_clear_i` pulsed in the same cycle as a new `fall_o` with `fall_en_i`=1 → `intr_state_o` remains 1; a clear the next cycle → 0.
- `debounce_en_i` dropped at counter=10 with the pin mismatched → `value_q` follows `sync` on the next edge and a single edge pulse is produced.
- `rise_en_i`=0, `fall_en_i`=1, pin toggled 0→1→0 → both `rise_o` and `fall_o` pulse; `intr_state_o` sets only after the fall.

Source files
------------

// File: rtl/pin_input_conditioner.sv
// Per-pin input conditioner: synchroniser, debounce, edge detect, sticky irq.
// Optional glitch counters: define PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN.
module pin_input_conditioner #(
    parameter int NumberOfPins   = 1,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumberOfPins-1:0]     from_pins_i,
    input  logic [NumberOfPins-1:0]     debounce_en_i,
    input  logic [NumberOfPins-1:0]     rise_en_i,
    input  logic [NumberOfPins-1:0]     fall_en_i,
    input  logic [NumberOfPins-1:0]     intr_clear_i,
`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
    input  logic [NumberOfPins-1:0]     glitch_clear_i,
    output logic [8*NumberOfPins-1:0]   glitch_count_o,
`endif
    output logic [NumberOfPins-1:0]     pin_value_o,
    output logic [NumberOfPins-1:0]     rise_o,
    output logic [NumberOfPins-1:0]     fall_o,
    output logic [NumberOfPins-1:0]     intr_state_o,
    output logic                        intr_o
);

    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    for (genvar gi = 0; gi < NumberOfPins; gi++) begin : g_pin
        logic [SyncStages-1:0] r_sync;
        logic                  w_sync;
        logic [CntW-1:0]       r_cnt;
        logic [CntW-1:0]       w_cnt_d;
        logic                  r_value;
        logic                  w_value_d;
        logic                  r_prev;
        logic                  r_intr;
        logic                  w_rise;
        logic                  w_fall;
        logic                  w_set;

        assign w_sync = r_sync[SyncStages-1];

        // Shift the asynchronous pad value through the synchroniser chain.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SyncStages-2:0], from_pins_i[gi]};
            end
        end

        // Debounce decision: accept a new value after enough stable mismatches.
        always_comb begin
            w_value_d = r_value;
            w_cnt_d   = '0;
            if (!debounce_en_i[gi]) begin
                w_value_d = w_sync;
            end else if (w_sync != r_value) begin
                if (r_cnt == CntLast) begin
                    w_value_d = w_sync;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
        end

        // Accepted value, stability counter and previous value for edges.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_value <= 1'b0;
                r_cnt   <= '0;
                r_prev  <= 1'b0;
            end else begin
                r_value <= w_value_d;
                r_cnt   <= w_cnt_d;
                r_prev  <= r_value;
            end
        end

        assign w_rise = r_value & ~r_prev;
        assign w_fall = ~r_value & r_prev;
        assign w_set  = (w_rise & rise_en_i[gi])
                      | (w_fall & fall_en_i[gi]);

        // Sticky edge status; a new set beats a simultaneous clear.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_intr <= 1'b0;
            end else begin
                r_intr <= w_set | (r_intr & ~intr_clear_i[gi]);
            end
        end

        assign pin_value_o[gi]  = r_value;
        assign rise_o[gi]       = w_rise;
        assign fall_o[gi]       = w_fall;
        assign intr_state_o[gi] = r_intr;

`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
        logic [7:0] r_glitch;
        logic       w_glitch;

        // A glitch is a partial count abandoned because sync fell back.
        assign w_glitch = debounce_en_i[gi]
                        & (r_cnt != '0)
                        & (w_sync == r_value);

        // Saturating glitch counter; clear has priority over increment.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_glitch <= 8'd0;
            end else if (glitch_clear_i[gi]) begin
                r_glitch <= 8'd0;
            end else if (w_glitch && r_glitch != 8'hFF) begin
                r_glitch <= r_glitch + 8'd1;
            end
        end

        assign glitch_count_o[8*gi +: 8] = r_glitch;
`endif
    end

    assign intr_o = |intr_state_o;

endmodule

// File: tb/tb_pin_input_conditioner.sv
// Directed bench for pin_input_conditioner (one pin, 2 sync stages,
// 16 debounce cycles).
module tb_pin_input_conditioner;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic from_pins_i;
    logic debounce_en_i;
    logic rise_en_i;
    logic fall_en_i;
    logic intr_clear_i;
    logic pin_value_o;
    logic rise_o;
    logic fall_o;
    logic intr_state_o;
    logic intr_o;
`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic       glitch_clear_i;
    logic [7:0] glitch_count_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    pin_input_conditioner #(
        .NumberOfPins   (1),
        .SyncStages     (2),
        .DebounceCycles (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .from_pins_i    (from_pins_i),
        .debounce_en_i  (debounce_en_i),
        .rise_en_i      (rise_en_i),
        .fall_en_i      (fall_en_i),
        .intr_clear_i   (intr_clear_i),
`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
        .glitch_clear_i (glitch_clear_i),
        .glitch_count_o (glitch_count_o),
`endif
        .pin_value_o    (pin_value_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .intr_state_o   (intr_state_o),
        .intr_o         (intr_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        from_pins_i   = 1'b1;
        debounce_en_i = 1'b0;
        rise_en_i     = 1'b1;
        fall_en_i     = 1'b0;
        intr_clear_i  = 1'b0;
`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
        glitch_clear_i = 1'b0;
`endif
        step();
        step();
        step();
        chk("rst_value", pin_value_o, 0);
        chk("rst_rise", rise_o, 0);
        chk("rst_fall", fall_o, 0);
        chk("rst_intr_state", intr_state_o, 0);
        chk("rst_intr", intr_o, 0);

        // Pin held high through reset, debounce off.
        rst_ni = 1'b1;
        step();
        chk("r_e1_value", pin_value_o, 0);
        step();
        chk("r_e2_value", pin_value_o, 0);
        step();
        chk("r_e3_value", pin_value_o, 1);
        chk("r_e3_rise", rise_o, 1);
        chk("r_e3_intr", intr_state_o, 0);
        step();
        chk("r_e4_rise", rise_o, 0);
        chk("r_e4_intr_state", intr_state_o, 1);
        chk("r_e4_intr", intr_o, 1);

        // Fall with simultaneous clear: set wins, then clear next cycle.
        fall_en_i   = 1'b1;
        from_pins_i = 1'b0;
        step();
        chk("f_e1_value", pin_value_o, 1);
        step();
        chk("f_e2_value", pin_value_o, 1);
        step();
        chk("f_e3_value", pin_value_o, 0);
        chk("f_e3_fall", fall_o, 1);
        intr_clear_i = 1'b1;
        step();
        chk("f_setwins_state", intr_state_o, 1);
        chk("f_e4_fall", fall_o, 0);
        step();
        chk("f_clear_state", intr_state_o, 0);
        chk("f_clear_intr", intr_o, 0);
        intr_clear_i = 1'b0;
        fall_en_i    = 1'b0;

        // Debounced rise: value appears exactly 18 edges after the change.
        debounce_en_i = 1'b1;
        from_pins_i   = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("d_e%0d_value", k), pin_value_o, 0);
            chk($sformatf("d_e%0d_fall", k), fall_o, 0);
        end
        step();
        chk("d_e18_value", pin_value_o, 1);
        chk("d_e18_rise", rise_o, 1);
        chk("d_e18_fall", fall_o, 0);
        step();
        chk("d_e19_rise", rise_o, 0);
        chk("d_e19_intr", intr_state_o, 1);
        intr_clear_i = 1'b1;
        step();
        chk("d_clear", intr_state_o, 0);
        intr_clear_i = 1'b0;

        // Return low without debounce, then reject a 10-cycle glitch.
        debounce_en_i = 1'b0;
        from_pins_i   = 1'b0;
        step();
        step();
        step();
        chk("g_low_value", pin_value_o, 0);
        chk("g_low_fall", fall_o, 1);
        chk("g_low_nointr", intr_state_o, 0);
        debounce_en_i = 1'b1;
        step();
        step();
        from_pins_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("g_hi_value", pin_value_o, 0);
            chk("g_hi_rise", rise_o, 0);
        end
        from_pins_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("g_lo_value", pin_value_o, 0);
            chk("g_lo_rise", rise_o, 0);
        end
`ifdef PIN_INPUT_CONDITIONER_GLITCH_COUNT_EN
        chk("g_count_1", glitch_count_o, 1);
        for (int n = 0; n < 300; n++) begin
            from_pins_i = 1'b1;
            repeat (10) step();
            from_pins_i = 1'b0;
            repeat (4) step();
        end
        chk("g_count_sat", glitch_count_o, 255);
        chk("g_sat_value", pin_value_o, 0);
        glitch_clear_i = 1'b1;
        step();
        chk("g_count_clr", glitch_count_o, 0);
        glitch_clear_i = 1'b0;
`endif

        // Debounce dropped with counter at 10 while mismatched.
        rise_en_i   = 1'b0;
        from_pins_i = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("x_count_value", pin_value_o, 0);
        end
        debounce_en_i = 1'b0;
        step();
        chk("x_drop_value", pin_value_o, 1);
        chk("x_drop_rise", rise_o, 1);
        step();
        chk("x_after_rise", rise_o, 0);
        chk("x_after_fall", fall_o, 0);
        chk("x_after_value", pin_value_o, 1);
        chk("x_no_intr", intr_state_o, 0);

        // Bring low, then rise-disabled / fall-enabled toggle 0->1->0.
        from_pins_i = 1'b0;
        repeat (3) step();
        chk("t_low_value", pin_value_o, 0);
        step();
        fall_en_i   = 1'b1;
        from_pins_i = 1'b1;
        step();
        step();
        step();
        chk("t_rise", rise_o, 1);
        chk("t_rise_intr", intr_state_o, 0);
        step();
        chk("t_rise_intr_next", intr_state_o, 0);
        from_pins_i = 1'b0;
        step();
        step();
        step();
        chk("t_fall", fall_o, 1);
        chk("t_fall_intr", intr_state_o, 0);
        step();
        chk("t_fall_intr_next", intr_state_o, 1);
        chk("t_fall_intr_o", intr_o, 1);
        fall_en_i = 1'b0;
        step();
        chk("t_disable_keeps", intr_state_o, 1);
        intr_clear_i = 1'b1;
        step();
        chk("t_final_clear", intr_state_o, 0);
        intr_clear_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
